// File: rtl/systolic_pe_array.sv
// Output-stationary systolic array of ROWS_P x COLS_P signed MAC PEs.
// Data enters per column and flows down. Weights enter per row and flow right.
// Skew is generated internally, so callers present aligned vectors.
// A job is: IDLE -> STREAM (k_len beats) -> FLUSH (ROWS_P+COLS_P-1 cycles)
// -> DRAIN (row-major result readout) -> IDLE.
// Optional build macro: SYSTOLIC_PE_ARRAY_SATURATE_EN makes the accumulators
// saturate and stick at the rail until the next start; otherwise they wrap.
// Ports:
//   clk_i, reset_i         clock and synchronous active-high reset
//   start_i, k_len_i       job start (sampled in IDLE) and beat count
//   valid_i, ready_o       input beat handshake
//   data_i                 one signed element per column, column 0 in the LSBs
//   weights_i              one signed weight per row, row 0 in the LSBs
//   res_v_o, res_ready_i   result handshake
//   res_o                  result value
//   res_row_o, res_col_o   position of res_o in the array
//   busy_o                 high whenever the array is not IDLE
//   done_o                 one-cycle pulse after the last result handshake
module systolic_pe_array #(
  parameter int unsigned ROWS_P   = 2,
  parameter int unsigned COLS_P   = 2,
  parameter int unsigned DATA_W_P = 8,
  parameter int unsigned ACC_W_P  = 24,
  parameter int unsigned K_W_P    = 8
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic                                           start_i,
  input  logic [K_W_P-1:0]                               k_len_i,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  input  logic [COLS_P*DATA_W_P-1:0]                     data_i,
  input  logic [ROWS_P*DATA_W_P-1:0]                     weights_i,
  output logic                                           res_v_o,
  input  logic                                           res_ready_i,
  output logic [ACC_W_P-1:0]                             res_o,
  output logic [((ROWS_P > 1) ? $clog2(ROWS_P) : 1)-1:0] res_row_o,
  output logic [((COLS_P > 1) ? $clog2(COLS_P) : 1)-1:0] res_col_o,
  output logic                                           busy_o,
  output logic                                           done_o
);

  localparam int unsigned ROW_W      = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;
  localparam int unsigned COL_W      = (COLS_P > 1) ? $clog2(COLS_P) : 1;
  localparam int unsigned FL_W       = $clog2(ROWS_P + COLS_P) + 1;
  localparam int unsigned FLUSH_LAST = ROWS_P + COLS_P - 2;
  localparam int unsigned PROD_W     = 2 * DATA_W_P;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [K_W_P-1:0]   k_len_q, k_len_d;
  logic [K_W_P-1:0]   beat_q, beat_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [ROW_W-1:0]   row_q, row_d, nxt_row;
  logic [COL_W-1:0]   col_q, col_d, nxt_col;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               res_v_q, res_v_d;
  logic [ACC_W_P-1:0] res_q, res_d;

  logic in_v;
  logic clr;

  // Operand fabric: inputs seen by each PE, and each PE's accumulator.
  logic [DATA_W_P-1:0] pe_d_in [ROWS_P][COLS_P];
  logic                pe_v_in [ROWS_P][COLS_P];
  logic [DATA_W_P-1:0] pe_w_in [ROWS_P][COLS_P];
  logic [ACC_W_P-1:0]  acc     [ROWS_P][COLS_P];

  assign in_v = valid_i & ready_q;
  assign clr  = (state_q == IDLE) & start_i;

  // Job sequencing and result readout.
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    col_d   = col_q;
    res_v_d = res_v_q;
    res_d   = res_q;
    done_d  = 1'b0;
    nxt_row = row_q;
    nxt_col = col_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          k_len_d = k_len_i;
          beat_d  = '0;
          flush_d = '0;
          state_d = (k_len_i == '0) ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (in_v) begin
          beat_d = beat_q + K_W_P'(1);
          if (beat_q + K_W_P'(1) == k_len_q) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_q == FL_W'(FLUSH_LAST)) begin
          state_d = DRAIN;
          row_d   = '0;
          col_d   = '0;
          res_v_d = 1'b1;
          res_d   = acc[0][0];
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      DRAIN: begin
        if (res_v_q && res_ready_i) begin
          if (row_q == ROW_W'(ROWS_P - 1) && col_q == COL_W'(COLS_P - 1)) begin
            state_d = IDLE;
            res_v_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (col_q == COL_W'(COLS_P - 1)) begin
              nxt_col = '0;
              nxt_row = row_q + ROW_W'(1);
            end else begin
              nxt_col = col_q + COL_W'(1);
            end
            row_d = nxt_row;
            col_d = nxt_col;
            res_d = acc[nxt_row][nxt_col];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == STREAM);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_v_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_v_q <= res_v_d;
      res_q   <= res_d;
    end
  end

  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign res_v_o   = res_v_q;
  assign res_o     = res_q;
  assign res_row_o = row_q;
  assign res_col_o = col_q;

  genvar gr, gc;

  // Column c data (with its valid bit) is delayed by c registers.
  for (gc = 0; gc < COLS_P; gc++) begin : g_dskew
    if (gc == 0) begin : g_pass
      assign pe_d_in[0][0] = data_i[DATA_W_P-1:0];
      assign pe_v_in[0][0] = in_v;
    end else begin : g_chain
      logic [DATA_W_P-1:0] sk_d [gc];
      logic [DATA_W_P-1:0] sk_q [gc];
      logic                sv_d [gc];
      logic                sv_q [gc];
      always_comb begin
        sk_d[0] = data_i[gc*DATA_W_P +: DATA_W_P];
        sv_d[0] = in_v;
        for (int i = 1; i < gc; i++) begin
          sk_d[i] = sk_q[i-1];
          sv_d[i] = sv_q[i-1];
        end
      end
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < gc; i++) begin
            sk_q[i] <= '0;
            sv_q[i] <= 1'b0;
          end
        end else begin
          sk_q <= sk_d;
          sv_q <= sv_d;
        end
      end
      assign pe_d_in[0][gc] = sk_q[gc-1];
      assign pe_v_in[0][gc] = sv_q[gc-1];
    end
  end

  // Row r weight is delayed by r registers.
  for (gr = 0; gr < ROWS_P; gr++) begin : g_wskew
    if (gr == 0) begin : g_pass
      assign pe_w_in[0][0] = weights_i[DATA_W_P-1:0];
    end else begin : g_chain
      logic [DATA_W_P-1:0] sk_d [gr];
      logic [DATA_W_P-1:0] sk_q [gr];
      always_comb begin
        sk_d[0] = weights_i[gr*DATA_W_P +: DATA_W_P];
        for (int i = 1; i < gr; i++) begin
          sk_d[i] = sk_q[i-1];
        end
      end
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < gr; i++) begin
            sk_q[i] <= '0;
          end
        end else begin
          sk_q <= sk_d;
        end
      end
      assign pe_w_in[gr][0] = sk_q[gr-1];
    end
  end

  // PE grid: MAC plus registered forwarding of data down and weights right.
  for (gr = 0; gr < ROWS_P; gr++) begin : g_row
    for (gc = 0; gc < COLS_P; gc++) begin : g_col
      logic signed [PROD_W-1:0] prod;
      logic [ACC_W_P-1:0]       acc_d, acc_q;

      assign prod = PROD_W'($signed(pe_d_in[gr][gc])) * PROD_W'($signed(pe_w_in[gr][gc]));

`ifdef SYSTOLIC_PE_ARRAY_SATURATE_EN
      localparam logic [ACC_W_P-1:0] ACC_MAX = {1'b0, {(ACC_W_P-1){1'b1}}};
      localparam logic [ACC_W_P-1:0] ACC_MIN = {1'b1, {(ACC_W_P-1){1'b0}}};
      logic                      sat_d, sat_q;
      logic signed [ACC_W_P:0]   sum_wide;

      // One guard bit detects overflow; once railed the PE ignores further beats.
      always_comb begin
        acc_d    = acc_q;
        sat_d    = sat_q;
        sum_wide = (ACC_W_P+1)'($signed(acc_q)) + (ACC_W_P+1)'(prod);
        if (clr) begin
          acc_d = '0;
          sat_d = 1'b0;
        end else if (pe_v_in[gr][gc] && !sat_q) begin
          if (sum_wide[ACC_W_P] != sum_wide[ACC_W_P-1]) begin
            acc_d = sum_wide[ACC_W_P] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
          end else begin
            acc_d = sum_wide[ACC_W_P-1:0];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end else begin
          acc_q <= acc_d;
          sat_q <= sat_d;
        end
      end
`else
      always_comb begin
        acc_d = acc_q;
        if (clr) begin
          acc_d = '0;
        end else if (pe_v_in[gr][gc]) begin
          acc_d = acc_q + ACC_W_P'(prod);
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
`endif

      assign acc[gr][gc] = acc_q;

      if (gr < ROWS_P - 1) begin : g_down
        logic [DATA_W_P-1:0] dn_d, dn_q;
        logic                dv_d, dv_q;
        always_comb begin
          dn_d = pe_d_in[gr][gc];
          dv_d = pe_v_in[gr][gc];
        end
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            dn_q <= '0;
            dv_q <= 1'b0;
          end else begin
            dn_q <= dn_d;
            dv_q <= dv_d;
          end
        end
        assign pe_d_in[gr+1][gc] = dn_q;
        assign pe_v_in[gr+1][gc] = dv_q;
      end

      if (gc < COLS_P - 1) begin : g_right
        logic [DATA_W_P-1:0] rt_d, rt_q;
        always_comb begin
          rt_d = pe_w_in[gr][gc];
        end
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            rt_q <= '0;
          end else begin
            rt_q <= rt_d;
          end
        end
        assign pe_w_in[gr][gc+1] = rt_q;
      end
    end
  end

endmodule

// File: doc/systolic_pe_array.md
Name: systolic_pe_array

Overview:
Parametrised output-stationary systolic array of ROWS_P x COLS_P multiply-accumulate PEs, the generalised successor of the fixed 2x2 PE tile.
- Data enters per column and flows down; weights enter per row and flow right.
- Input skew is generated internally, so the caller presents aligned vectors.
- Stream length is configurable, with valid/ready input and output handshakes.
- Results drain serially after a flush phase.

Parameters:
ROWS_P, 2, PE rows (weight lanes), >=1
COLS_P, 2, PE columns (data lanes), >=1
DATA_W_P, 8, signed operand width (data and weight)
ACC_W_P, 24, signed accumulator/result width, >= 2*DATA_W_P
K_W_P, 8, width of stream-length field

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous active-high reset
start_i  in  1  begin job; sampled only in IDLE
k_len_i  in  K_W_P  number of input beats in job (unsigned)
valid_i  in  1  input beat valid
ready_o  out  1  array accepts beat
data_i  in  COLS_P*DATA_W_P  one signed data element per column, column 0 in LSBs
weights_i  in  ROWS_P*DATA_W_P  one signed weight per row, row 0 in LSBs
res_v_o  out  1  result valid
res_ready_i  in  1  result consumer ready
res_o  out  ACC_W_P  signed accumulator value
res_row_o  out  $clog2(ROWS_P)  row index of res_o (min width 1)
res_col_o  out  $clog2(COLS_P)  column index of res_o (min width 1)
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset: state IDLE; all accumulators, skew and pipeline registers, and counters cleared; ready_o=0, res_v_o=0, done_o=0, busy_o=0, res_o=0.
- FSM states: IDLE, STREAM, FLUSH, DRAIN.
  - IDLE: start_i=1 -> clear all accumulators, latch k_len_i, beat counter=0 -> STREAM. If k_len_i=0, go directly to FLUSH.
  - STREAM: ready_o=1. A beat transfers when valid_i&ready_o. When the counter reaches the latched k_len: ready_o drops the following cycle -> FLUSH.
  - FLUSH: ready_o=0. Runs exactly ROWS_P+COLS_P-1 cycles, then -> DRAIN.
  - DRAIN: emits results row-major (r=0..ROWS_P-1, c=0..COLS_P-1), one per res_v_o&res_ready_i handshake.
    - res_o, res_row_o and res_col_o are held stable while res_v_o=1 and res_ready_i=0.
    - After the last handshake: done_o=1 for one cycle -> IDLE.
- Skew and propagation:
  - Column c data passes through c skew registers; row r weight passes through r skew registers.
  - Each PE registers its data outputs to PE(r+1,c) and its weight outputs to PE(r,c+1).
  - Each operand pair carries a valid bit, so beat k reaches PE(r,c) exactly r+c cycles after its acceptance cycle.
- Bubbles: a cycle with valid_i=0 in STREAM injects a valid=0 slot. PEs accumulate only when the incoming valid bit is 1.
- PE arithmetic:
  - acc <= acc + sext(d*w), a full-precision 2*DATA_W_P signed product sign-extended to ACC_W_P.
  - Default overflow behaviour: two's-complement wrap.
- start_i is ignored outside IDLE. valid_i is ignored outside STREAM.
- Reset asserted mid-job aborts immediately and returns to the reset state; no done_o is produced.
- Result ordering and values are independent of input bubbles and output backpressure.

Optional Feature:
Macro SYSTOLIC_PE_ARRAY_SATURATE_EN.
- Defined: each PE accumulation saturates at +(2^(ACC_W_P-1)-1) and -(2^(ACC_W_P-1)), and sticks at the rail until the next start.
- Undefined: two's-complement wrap.
- Port list is identical in both builds.

Test Plan:
- 2x2, k_len=3, no bubbles; data col0=[1,2,3], col1=[4,5,6]; weights row0=[1,1,1], row1=[2,0,-1] -> results in order (0,0)=6, (0,1)=15, (1,0)=-1, (1,1)=2; then done_o pulses once and busy_o falls.
- Same stimulus with valid_i deasserted on alternate cycles and res_ready_i low for 3 cycles in DRAIN -> identical values and order; res_o held stable while stalled.
- k_len=0 -> FLUSH for ROWS_P+COLS_P-1 cycles, then four results of 0, then done_o.
- Reset asserted during FLUSH of a k_len=3 job -> next cycle ready_o=0, busy_o=0, res_v_o=0; a new job of k_len=1 with d=[2,3], w=[4,5] -> results 8, 12, 10, 15.
- DATA_W_P=8, ACC_W_P=16, k_len=3, all operands 127 -> with SYSTOLIC_PE_ARRAY_SATURATE_EN all results 32767; without it all results -17149.
- 4x3 configuration, k_len=5 with random operands -> all 12 results match a reference matrix product; start_i pulsed during STREAM has no effect.
